// File: rtl/bike_pkg.sv
// -----------------------------------------------------------------------------
// bike_pkg
//   Shared definitions for the bike sensor front-end blocks.
//   - rc_state_e      : reed conditioner wheel state (stopped / running)
//   - BIKE_CLK_PER_MS : default clock cycles per millisecond (1 MHz system clock)
//   - BIKE_PERIOD_W   : width of millisecond period values, shared with Speed
// -----------------------------------------------------------------------------
package bike_pkg;

    localparam int BIKE_CLK_PER_MS = 1000;
    localparam int BIKE_PERIOD_W   = 13;

    typedef enum logic {
        RC_STOPPED = 1'b0,
        RC_RUNNING = 1'b1
    } rc_state_e;

endpackage : bike_pkg

// File: rtl/reed_conditioner_if.sv
// -----------------------------------------------------------------------------
// reed_conditioner_if
//   Signal bundle between the raw reed switch, the reed conditioner and its
//   consumers (distance, Speed).
//   reed         : raw, bouncy reed switch level (asynchronous to clock)
//   reed_pulse   : one-cycle pulse per accepted revolution
//   period_ms    : ms between the last two accepted pulses, 0 when stopped
//   period_valid : one-cycle strobe, period_ms updated this cycle
//   stopped      : wheel considered stopped
//   glitch_cnt   : saturating count of rejected edges (0 unless enabled)
//   Modports: slave = the conditioner, master = the environment around it.
// -----------------------------------------------------------------------------
interface reed_conditioner_if #(
    parameter int PERIOD_W = bike_pkg::BIKE_PERIOD_W
) ();

    logic                reed;
    logic                reed_pulse;
    logic [PERIOD_W-1:0] period_ms;
    logic                period_valid;
    logic                stopped;
    logic [7:0]          glitch_cnt;

    modport slave (
        input  reed,
        output reed_pulse,
        output period_ms,
        output period_valid,
        output stopped,
        output glitch_cnt
    );

    modport master (
        output reed,
        input  reed_pulse,
        input  period_ms,
        input  period_valid,
        input  stopped,
        input  glitch_cnt
    );

endinterface : reed_conditioner_if

// File: rtl/ms_prescaler.sv
// -----------------------------------------------------------------------------
// ms_prescaler
//   Free-running divider producing a one-cycle tick once per millisecond.
//   Counts 0..CLK_PER_MS-1; tick is high during the cycle the count wraps.
//   Ports:
//     clock : system clock
//     reset : asynchronous, active-high reset (count cleared)
//     tick  : one-cycle millisecond tick
// -----------------------------------------------------------------------------
module ms_prescaler #(
    parameter int CLK_PER_MS = bike_pkg::BIKE_CLK_PER_MS
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int               CNT_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_PER_MS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every combinational output gets its default before any branch so no
    // path leaves it unassigned; an unassigned path would infer a latch.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of process order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule : ms_prescaler

// File: rtl/reed_conditioner.sv
// -----------------------------------------------------------------------------
// reed_conditioner
//   Reed switch front-end: 2-flop synchroniser, debouncer, lockout rate
//   limiter and revolution period measurement with stop detection.
//   Ports:
//     clock : system clock
//     reset : asynchronous, active-high reset
//     bus   : reed_conditioner_if.slave (reed in; reed_pulse, period_ms,
//             period_valid, stopped, glitch_cnt out)
//   Configuration:
//     REED_GLITCH_CNT_EN : when defined, glitch_cnt is an 8-bit saturating
//                          count of edges rejected by the lockout; otherwise
//                          glitch_cnt is tied to zero.
//   Latency: reed_pulse rises 2 + DEB_CYCLES + 1 cycles after the reed input
//   settles high.
// -----------------------------------------------------------------------------
module reed_conditioner
    import bike_pkg::*;
#(
    parameter int CLK_PER_MS = BIKE_CLK_PER_MS,
    parameter int DEB_CYCLES = 16,
    parameter int LOCKOUT_MS = 60,
    parameter int STOP_MS    = 4000,
    parameter int PERIOD_W   = BIKE_PERIOD_W
) (
    input  logic              clock,
    input  logic              reset,
    reed_conditioner_if.slave bus
);

    localparam int                  DEB_W     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0]    DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam int                  LOCK_W    = $clog2(LOCKOUT_MS + 1);
    localparam logic [LOCK_W-1:0]   LOCK_LOAD = LOCK_W'(LOCKOUT_MS);
    localparam logic [PERIOD_W-1:0] STOP_VAL  = PERIOD_W'(STOP_MS);

    logic tick;

    ms_prescaler #(
        .CLK_PER_MS (CLK_PER_MS)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // Synchroniser and debouncer state
    logic             sync1_q, sync2_q;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             deb_level_q, deb_level_d;
    logic             deb_prev_q;

    // Lockout and measurement state
    logic [LOCK_W-1:0]   lockout_q, lockout_d;
    rc_state_e           state_q, state_d;
    logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
    logic [PERIOD_W-1:0] period_ms_q, period_ms_d;
    logic                period_valid_q, period_valid_d;
    logic                pulse_q, pulse_d;

    logic                rise;
    logic                accept;
    logic [PERIOD_W-1:0] period_cnt_inc;

    // Debounce: the level only follows the synced input after DEB_CYCLES
    // consecutive differing samples; any agreeing sample restarts the count.
    always_comb begin
        deb_cnt_d   = '0;
        deb_level_d = deb_level_q;
        if (sync2_q != deb_level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_level_d = ~deb_level_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    assign rise   = deb_level_q & ~deb_prev_q;
    assign accept = rise && (lockout_q == '0);

    always_comb begin
        lockout_d = lockout_q;
        if (accept) begin
            lockout_d = LOCK_LOAD;
        end else if (tick && (lockout_q != '0)) begin
            lockout_d = lockout_q - 1'b1;
        end
    end

    // Period counter including this cycle's tick, so a pulse landing on the
    // STOP_MS tick reports STOP_MS rather than being lost to the timeout.
    assign period_cnt_inc = period_cnt_q + {{(PERIOD_W-1){1'b0}}, tick};

    always_comb begin
        state_d        = state_q;
        period_cnt_d   = period_cnt_q;
        period_ms_d    = period_ms_q;
        period_valid_d = 1'b0;
        pulse_d        = accept;
        unique case (state_q)
            RC_STOPPED: begin
                // First pulse after a stop has no reference edge: no period.
                if (accept) begin
                    state_d      = RC_RUNNING;
                    period_cnt_d = '0;
                end
            end
            RC_RUNNING: begin
                period_cnt_d = period_cnt_inc;
                if (accept) begin
                    period_ms_d    = period_cnt_inc;
                    period_valid_d = 1'b1;
                    period_cnt_d   = '0;
                end else if (tick && (period_cnt_inc == STOP_VAL)) begin
                    state_d        = RC_STOPPED;
                    period_ms_d    = '0;
                    period_valid_d = 1'b1;
                    period_cnt_d   = '0;
                end
            end
            default: begin
                state_d = RC_STOPPED;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            deb_cnt_q      <= '0;
            deb_level_q    <= 1'b0;
            deb_prev_q     <= 1'b0;
            lockout_q      <= '0;
            state_q        <= RC_STOPPED;
            period_cnt_q   <= '0;
            period_ms_q    <= '0;
            period_valid_q <= 1'b0;
            pulse_q        <= 1'b0;
        end else begin
            sync1_q        <= bus.reed;
            sync2_q        <= sync1_q;
            deb_cnt_q      <= deb_cnt_d;
            deb_level_q    <= deb_level_d;
            deb_prev_q     <= deb_level_q;
            lockout_q      <= lockout_d;
            state_q        <= state_d;
            period_cnt_q   <= period_cnt_d;
            period_ms_q    <= period_ms_d;
            period_valid_q <= period_valid_d;
            pulse_q        <= pulse_d;
        end
    end

    assign bus.reed_pulse   = pulse_q;
    assign bus.period_ms    = period_ms_q;
    assign bus.period_valid = period_valid_q;
    assign bus.stopped      = (state_q == RC_STOPPED);

`ifdef REED_GLITCH_CNT_EN
    logic       reject;
    logic [7:0] glitch_q;

    assign reject = rise & ~accept;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            glitch_q <= 8'd0;
        end else if (reject && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign bus.glitch_cnt = glitch_q;
`else
    assign bus.glitch_cnt = 8'd0;
`endif

endmodule : reed_conditioner

// File: tb/tb_reed_conditioner.sv
`timescale 1ns/1ps
module tb_reed_conditioner;

    localparam int CLK_PER_MS = 10;
    localparam int DEB_CYCLES = 4;
    localparam int LOCKOUT_MS = 3;
    localparam int STOP_MS    = 20;
    localparam int PERIOD_W   = 13;

`ifdef REED_GLITCH_CNT_EN
    localparam logic [7:0] EXP_GLITCH = 8'd1;
`else
    localparam logic [7:0] EXP_GLITCH = 8'd0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    // Observation counters, sampled on the falling edge
    int                  pulse_cnt        = 0;
    int                  valid_cnt        = 0;
    logic [PERIOD_W-1:0] last_period      = '0;
    logic                valid_with_pulse = 1'b0;

    // Rising edges since the last reset release; mirrors the ms tick phase
    int pcount = 0;

    reed_conditioner_if #(.PERIOD_W(PERIOD_W)) bus ();

    reed_conditioner #(
        .CLK_PER_MS (CLK_PER_MS),
        .DEB_CYCLES (DEB_CYCLES),
        .LOCKOUT_MS (LOCKOUT_MS),
        .STOP_MS    (STOP_MS),
        .PERIOD_W   (PERIOD_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock or posedge reset) begin
        if (reset) pcount <= 0;
        else       pcount <= pcount + 1;
    end

    always @(negedge clock) begin
        if (bus.reed_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
        if (bus.period_valid === 1'b1) begin
            valid_cnt        <= valid_cnt + 1;
            last_period      <= bus.period_ms;
            valid_with_pulse <= bus.reed_pulse;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset();
        int p0;
        bus.reed = 1'b0;
        reset    = 1'b1;
        wait_cyc(3);
        #1;
        n_checks++;
        if (bus.stopped !== 1'b1) $display("FAIL reset_stopped: got %b expected 1", bus.stopped);
        else n_pass++;
        n_checks++;
        if (bus.period_ms !== '0) $display("FAIL reset_period: got %0d expected 0", bus.period_ms);
        else n_pass++;
        n_checks++;
        if (bus.reed_pulse !== 1'b0) $display("FAIL reset_pulse: got %b expected 0", bus.reed_pulse);
        else n_pass++;
        n_checks++;
        if (bus.period_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.period_valid);
        else n_pass++;
        n_checks++;
        if (bus.glitch_cnt !== 8'd0) $display("FAIL reset_glitch: got %0d expected 0", bus.glitch_cnt);
        else n_pass++;

        @(negedge clock);
        reset = 1'b0;
        // One clean pulse to leave the stopped state
        bus.reed = 1'b1;
        wait_cyc(10);
        bus.reed = 1'b0;
        wait_cyc(40);
        #1;
        n_checks++;
        if (bus.stopped !== 1'b0) $display("FAIL reset_running_before: got %b expected 0", bus.stopped);
        else n_pass++;

        // Reset in the middle of a debounce that would otherwise complete
        @(negedge clock);
        bus.reed = 1'b1;
        wait_cyc(4);
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.stopped !== 1'b1) $display("FAIL midreset_stopped: got %b expected 1", bus.stopped);
        else n_pass++;
        n_checks++;
        if (bus.reed_pulse !== 1'b0 || bus.period_valid !== 1'b0)
            $display("FAIL midreset_strobes: got pulse=%b valid=%b expected 0/0", bus.reed_pulse, bus.period_valid);
        else n_pass++;
        @(negedge clock);
        bus.reed = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        p0 = pulse_cnt;
        wait_cyc(15);
        #1;
        n_checks++;
        if (pulse_cnt !== p0) $display("FAIL midreset_no_pulse: got %0d pulses expected 0", pulse_cnt - p0);
        else n_pass++;
        n_checks++;
        if (bus.stopped !== 1'b1) $display("FAIL midreset_stays_stopped: got %b expected 1", bus.stopped);
        else n_pass++;
    endtask

    task automatic test_bounce();
        int p0, v0, lat;
        @(negedge clock);
        p0 = pulse_cnt;
        v0 = valid_cnt;
        for (int i = 0; i < 10; i++) begin
            bus.reed = 1'b1;
            wait_cyc(2);
            bus.reed = 1'b0;
            wait_cyc(2);
        end
        bus.reed = 1'b1;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (lat < 0 && bus.reed_pulse === 1'b1) lat = k;
        end
        n_checks++;
        if (lat != 2 + DEB_CYCLES + 1) $display("FAIL bounce_latency: got %0d expected %0d", lat, 2 + DEB_CYCLES + 1);
        else n_pass++;
        wait_cyc(5);
        #1;
        n_checks++;
        if (pulse_cnt != p0 + 1) $display("FAIL bounce_pulse_count: got %0d expected 1", pulse_cnt - p0);
        else n_pass++;
        n_checks++;
        if (valid_cnt != v0) $display("FAIL bounce_no_valid: got %0d strobes expected 0", valid_cnt - v0);
        else n_pass++;
        n_checks++;
        if (bus.stopped !== 1'b0) $display("FAIL bounce_running: got %b expected 0", bus.stopped);
        else n_pass++;
    endtask

    task automatic test_period();
        int v0;
        @(negedge clock);
        bus.reed = 1'b0;
        wait_cyc(260);
        #1;
        n_checks++;
        if (bus.stopped !== 1'b1) $display("FAIL period_pre_stopped: got %b expected 1", bus.stopped);
        else n_pass++;
        @(negedge clock);
        bus.reed = 1'b1;
        wait_cyc(10);
        bus.reed = 1'b0;
        wait_cyc(90);
        v0 = valid_cnt;
        bus.reed = 1'b1;
        wait_cyc(10);
        bus.reed = 1'b0;
        wait_cyc(10);
        #1;
        n_checks++;
        if (valid_cnt != v0 + 1) $display("FAIL period_valid_count: got %0d expected 1", valid_cnt - v0);
        else n_pass++;
        n_checks++;
        if (last_period < 9 || last_period > 11) $display("FAIL period_value: got %0d expected 10 (+/-1)", last_period);
        else n_pass++;
        n_checks++;
        if (valid_with_pulse !== 1'b1) $display("FAIL period_with_pulse: got %b expected 1", valid_with_pulse);
        else n_pass++;
    endtask

    task automatic test_lockout();
        int p0, v0;
        wait_cyc(40);
        p0 = pulse_cnt;
        v0 = valid_cnt;
        bus.reed = 1'b1;               // accepted edge
        wait_cyc(10);
        bus.reed = 1'b0;
        wait_cyc(10);
        bus.reed = 1'b1;               // 2 ms later: inside lockout
        wait_cyc(10);
        bus.reed = 1'b0;
        wait_cyc(20);
        #1;
        n_checks++;
        if (pulse_cnt != p0 + 1) $display("FAIL lockout_reject: got %0d pulses expected 1", pulse_cnt - p0);
        else n_pass++;
        n_checks++;
        if (bus.glitch_cnt !== EXP_GLITCH) $display("FAIL lockout_glitch: got %0d expected %0d", bus.glitch_cnt, EXP_GLITCH);
        else n_pass++;
        @(negedge clock);
        bus.reed = 1'b1;               // about 5 ms after the accepted edge
        wait_cyc(10);
        bus.reed = 1'b0;
        wait_cyc(10);
        #1;
        n_checks++;
        if (pulse_cnt != p0 + 2) $display("FAIL lockout_accept: got %0d pulses expected 2", pulse_cnt - p0);
        else n_pass++;
        n_checks++;
        if (valid_cnt != v0 + 2) $display("FAIL lockout_valid_count: got %0d expected 2", valid_cnt - v0);
        else n_pass++;
        n_checks++;
        if (last_period < 4 || last_period > 6) $display("FAIL lockout_period: got %0d expected 5 (+/-1)", last_period);
        else n_pass++;
    endtask

    task automatic test_stop();
        int v0, p1, v1;
        wait_cyc(170);
        #1;
        v0 = valid_cnt;
        n_checks++;
        if (bus.stopped !== 1'b0) $display("FAIL stop_early: got %b expected 0", bus.stopped);
        else n_pass++;
        wait_cyc(20);
        #1;
        n_checks++;
        if (bus.stopped !== 1'b1) $display("FAIL stop_flag: got %b expected 1", bus.stopped);
        else n_pass++;
        n_checks++;
        if (valid_cnt != v0 + 1) $display("FAIL stop_valid_count: got %0d expected 1", valid_cnt - v0);
        else n_pass++;
        n_checks++;
        if (last_period !== '0 || valid_with_pulse !== 1'b0)
            $display("FAIL stop_period_zero: got period=%0d pulse=%b expected 0/0", last_period, valid_with_pulse);
        else n_pass++;
        @(negedge clock);
        p1 = pulse_cnt;
        v1 = valid_cnt;
        bus.reed = 1'b1;
        wait_cyc(10);
        #1;
        n_checks++;
        if (pulse_cnt != p1 + 1) $display("FAIL restart_pulse: got %0d expected 1", pulse_cnt - p1);
        else n_pass++;
        n_checks++;
        if (valid_cnt != v1) $display("FAIL restart_no_valid: got %0d strobes expected 0", valid_cnt - v1);
        else n_pass++;
        n_checks++;
        if (bus.stopped !== 1'b0) $display("FAIL restart_running: got %b expected 0", bus.stopped);
        else n_pass++;
        @(negedge clock);
        bus.reed = 1'b0;
        wait_cyc(10);
    endtask

    task automatic test_collision();
        int a, b, hit_at, v_after;
        logic                seen, hit_valid, hit_stopped;
        logic [PERIOD_W-1:0] hit_period;
        wait_cyc(40);
        bus.reed = 1'b1;
        a = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (a < 0 && bus.reed_pulse === 1'b1) a = pcount;
        end
        bus.reed = 1'b0;
        n_checks++;
        if (a < 0) begin
            $display("FAIL collision_ref_pulse: got none expected pulse within 12 cycles");
            return;
        end
        else n_pass++;
        // Land the next accepted pulse on the 20th ms tick after the reference
        b = (a / CLK_PER_MS) * CLK_PER_MS + STOP_MS * CLK_PER_MS;
        for (int k = 0; k < 400 && pcount < b - (DEB_CYCLES + 3); k++) @(negedge clock);
        bus.reed = 1'b1;
        seen = 1'b0;
        hit_at = -1;
        hit_valid = 1'b0;
        hit_stopped = 1'b1;
        hit_period = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (!seen && bus.reed_pulse === 1'b1) begin
                seen        = 1'b1;
                hit_at      = pcount;
                hit_valid   = bus.period_valid;
                hit_period  = bus.period_ms;
                hit_stopped = bus.stopped;
            end
        end
        bus.reed = 1'b0;
        n_checks++;
        if (hit_at != b) $display("FAIL collision_timing: got cycle %0d expected %0d", hit_at, b);
        else n_pass++;
        n_checks++;
        if (hit_valid !== 1'b1 || hit_period !== PERIOD_W'(STOP_MS))
            $display("FAIL collision_period: got valid=%b period=%0d expected 1/%0d", hit_valid, hit_period, STOP_MS);
        else n_pass++;
        n_checks++;
        if (hit_stopped !== 1'b0) $display("FAIL collision_running: got %b expected 0", hit_stopped);
        else n_pass++;
        v_after = valid_cnt;
        wait_cyc(5);
        #1;
        n_checks++;
        if (bus.stopped !== 1'b0 || valid_cnt != v_after)
            $display("FAIL collision_no_stop: got stopped=%b extra=%0d expected 0/0", bus.stopped, valid_cnt - v_after);
        else n_pass++;
    endtask

    initial begin
        bus.reed = 1'b0;
        test_reset();
        test_bounce();
        test_period();
        test_lockout();
        test_stop();
        test_collision();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_reed_conditioner
